v6_clkgen: RTL and testbench



---
 rtl/clkgen_pkg.sv | 11 +
 rtl/v6_clkgen_if.sv | 9 +
 rtl/rst_sync.sv | 13 +
 rtl/v6_clkgen.sv | 50 +++++
 tb/tb_v6_clkgen.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/clkgen_pkg.sv
// clkgen_pkg: shared constants and helpers for the clock-generation block and its benches.
package clkgen_pkg;
  localparam int LOCK_CYCLES_DEF = 64;
  localparam int CLK_PERIOD_NS = 5;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/v6_clkgen_if.sv
// v6_clkgen_if: generated clocks and lock indication leaving the clock tree.
interface v6_clkgen_if;
  logic clk_2x_0;
  logic clk_1x_90;
  logic clk_eth;
  logic pll_lock;
  modport master (output clk_2x_0, output clk_1x_90, output clk_eth, output pll_lock);
  modport slave  (input clk_2x_0, input clk_1x_90, input clk_eth, input pll_lock);
endinterface

// File: rtl/rst_sync.sv
// rst_sync: two-flop reset synchronizer, asynchronous assert and synchronous deassert.
module rst_sync (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_no
);
  logic [1:0] sync_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 2'b00;
    else sync_q <= {sync_q[0], 1'b1};
  end
  assign rst_no = sync_q[1];
endmodule

// File: rtl/v6_clkgen.sv
// v6_clkgen: portable model of the MMCM clock tree with full-rate, 90deg half-rate and Ethernet
// clocks plus a sticky lock indication released a fixed number of edges after reset.
module v6_clkgen
  import clkgen_pkg::*;
#(
  parameter int CLKIN_PERIOD_NS = 5,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic sysclk_p,
  input  logic sysclk_n,
  input  logic rst_n,
  v6_clkgen_if.master out_if
);
  localparam int CW = clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0] LOCK_V = CW'(LOCK_CYCLES);
  logic rst_sync_n;
  logic div_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lock_q, lock_d;
  logic unused_sysclk_n;
  assign unused_sysclk_n = sysclk_n;
  rst_sync u_rst_sync (
    .clk_i  (sysclk_p),
    .rst_ni (rst_n),
    .rst_no (rst_sync_n)
  );
  // Lock compares against the next count so it rises on the same edge the count saturates.
  always_comb begin
    cnt_d = (cnt_q == LOCK_V) ? cnt_q : cnt_q + 1'b1;
    lock_d = lock_q | (cnt_d == LOCK_V);
  end
  always_ff @(posedge sysclk_p or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      cnt_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
    end
  end
  // Falling-edge toggle places the half-rate rising edges a quarter period late: 90 degrees.
  always_ff @(negedge sysclk_p or negedge rst_sync_n) begin
    if (!rst_sync_n) div_q <= 1'b0;
    else div_q <= ~div_q;
  end
  assign out_if.clk_2x_0  = sysclk_p;
  assign out_if.clk_1x_90 = div_q;
  assign out_if.clk_eth   = div_q;
  assign out_if.pll_lock  = lock_q;
endmodule

// File: tb/tb_v6_clkgen.sv
// tb_v6_clkgen: scenario-driven bench with a per-edge scoreboard of lock and divider state.
`timescale 1ns/1ps
module tb_v6_clkgen;
  import clkgen_pkg::*;
  logic sysclk_p = 1'b0;
  logic rst_n = 1'b1;
  logic n_const = 1'b0;
  logic sysclk_n;
  int n_checks = 0;
  int n_fail = 0;
  int c2x_edges = 0;
  typedef struct {
    int k;
    logic l0;
    logic l1;
    logic c;
  } exp_t;
  exp_t sb[$];
  assign sysclk_n = n_const ? 1'b0 : ~sysclk_p;
  v6_clkgen_if if0 ();
  v6_clkgen_if if1 ();
  v6_clkgen u0 (
    .sysclk_p (sysclk_p),
    .sysclk_n (sysclk_n),
    .rst_n    (rst_n),
    .out_if   (if0)
  );
  v6_clkgen #(.LOCK_CYCLES(2)) u1 (
    .sysclk_p (sysclk_p),
    .sysclk_n (sysclk_n),
    .rst_n    (rst_n),
    .out_if   (if1)
  );
  always #(CLK_PERIOD_NS / 2.0) sysclk_p = ~sysclk_p;
  always @(if0.clk_2x_0) c2x_edges++;

  task automatic release_rst();
    @(negedge sysclk_p);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_edges(input int n);
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      sb.push_back(exp_t'{k: k, l0: (k >= 66), l1: (k >= 4), c: (k >= 3) && (((k - 2) % 2) == 1)});
      @(posedge sysclk_p);
      #1;
      e = sb.pop_front();
      n_checks++;
      if (if0.pll_lock !== e.l0) begin
        n_fail++;
        $display("FAIL lock64 edge %0d: got %b want %b", e.k, if0.pll_lock, e.l0);
      end
      n_checks++;
      if (if1.pll_lock !== e.l1) begin
        n_fail++;
        $display("FAIL lock2 edge %0d: got %b want %b", e.k, if1.pll_lock, e.l1);
      end
      n_checks++;
      if (if0.clk_1x_90 !== e.c) begin
        n_fail++;
        $display("FAIL clk_1x_90 edge %0d: got %b want %b", e.k, if0.clk_1x_90, e.c);
      end
      n_checks++;
      if (if0.clk_eth !== e.c) begin
        n_fail++;
        $display("FAIL clk_eth edge %0d: got %b want %b", e.k, if0.clk_eth, e.c);
      end
    end
  endtask

  task automatic test_reset();
    int start;
    rst_n = 1'b0;
    start = c2x_edges;
    for (int i = 0; i < 10; i++) begin
      @(negedge sysclk_p);
      #1;
      n_checks++;
      if ({if0.clk_1x_90, if0.clk_eth, if0.pll_lock, if1.pll_lock} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %b want 0000", i,
                 {if0.clk_1x_90, if0.clk_eth, if0.pll_lock, if1.pll_lock});
      end
      n_checks++;
      if (if0.clk_2x_0 !== 1'b0) begin
        n_fail++;
        $display("FAIL clk_2x_0_low cycle %0d: got %b want 0", i, if0.clk_2x_0);
      end
      @(posedge sysclk_p);
      #1;
      n_checks++;
      if (if0.clk_2x_0 !== 1'b1) begin
        n_fail++;
        $display("FAIL clk_2x_0_high cycle %0d: got %b want 1", i, if0.clk_2x_0);
      end
    end
    n_checks++;
    if (c2x_edges - start < 19) begin
      n_fail++;
      $display("FAIL clk_2x_0_toggles: got %0d want >=19", c2x_edges - start);
    end
  endtask

  task automatic test_lock_sequence();
    release_rst();
    run_edges(80);
  endtask

  task automatic test_divider_timing();
    realtime t0, t1, t2;
    logic sp;
    fork
      @(posedge if0.clk_1x_90);
      #50;
    join_any
    disable fork;
    t0 = $realtime;
    sp = sysclk_p;
    fork
      @(negedge if0.clk_1x_90);
      #50;
    join_any
    disable fork;
    t1 = $realtime;
    fork
      @(posedge if0.clk_1x_90);
      #50;
    join_any
    disable fork;
    t2 = $realtime;
    n_checks++;
    if (sp !== 1'b0) begin
      n_fail++;
      $display("FAIL div_phase: sysclk_p at clk_1x_90 rise got %b want 0", sp);
    end
    n_checks++;
    if ((t1 - t0) < 4.99 || (t1 - t0) > 5.01) begin
      n_fail++;
      $display("FAIL div_high_time: got %0t want 5ns", t1 - t0);
    end
    n_checks++;
    if ((t2 - t0) < 9.99 || (t2 - t0) > 10.01) begin
      n_fail++;
      $display("FAIL div_period: got %0t want 10ns", t2 - t0);
    end
  endtask

  task automatic test_glitch();
    @(posedge sysclk_p);
    #1.25 rst_n = 1'b0;
    #0.001;
    n_checks++;
    if ({if0.pll_lock, if0.clk_1x_90, if0.clk_eth, if1.pll_lock} !== 4'b0000) begin
      n_fail++;
      $display("FAIL glitch_drop: got %b want 0000",
               {if0.pll_lock, if0.clk_1x_90, if0.clk_eth, if1.pll_lock});
    end
    #0.999 rst_n = 1'b1;
    run_edges(70);
  endtask

  task automatic test_lock2();
    rst_n = 1'b0;
    #10;
    release_rst();
    run_edges(1004);
  endtask

  task automatic test_sysclk_n();
    n_const = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(posedge sysclk_p);
    #1;
    n_checks++;
    if ({if0.pll_lock, if0.clk_1x_90, if1.pll_lock} !== 3'b000) begin
      n_fail++;
      $display("FAIL sysclk_n_reset: got %b want 000", {if0.pll_lock, if0.clk_1x_90, if1.pll_lock});
    end
    release_rst();
    run_edges(80);
    n_const = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_lock_sequence();
    test_divider_timing();
    test_glitch();
    test_lock2();
    test_sysclk_n();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
